// File: rtl/rv_mem_arb.sv
// Shares one single-ported memory between instruction fetch and MEM-stage load/store.
// Latency: grant and memory strobe in the same cycle; read data returns MEM_LAT cycles after the grant.
// Backpressure: a requester that is not granted holds its request. Build option RV_MEM_ARB_RR_EN selects round-robin priority.
module rv_mem_arb #(
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [63:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [63:0] d_addr_i,
    input  logic [63:0] d_wdata_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [63:0] d_rdata_o,
    output logic        mem_en_o,
    output logic        mem_we_o,
    output logic [63:0] mem_addr_o,
    output logic [63:0] mem_wdata_o,
    input  logic [63:0] mem_rdata_i,
    output logic        busy_o
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t     state;
    logic [2:0] cnt;       // remaining cycles of the outstanding read
    logic       owner_d;   // 1: outstanding read belongs to the data port
    logic       lane;      // word lane of the outstanding fetch
    logic       rd_done;
    logic       gnt_ok;
    logic       pick_d;
    logic       if_gnt;
    logic       d_gnt;
    logic       rd_gnt;
    logic       unused_addr_bits;

    // Fetch addresses are word aligned; the low bits carry no information.
    assign unused_addr_bits = ^if_addr_i[1:0];

    // The counter holds 1 in the final cycle of a read: that is the rvalid cycle
    // and the counter reaches 0 at its closing edge.
    assign rd_done = (state == WAIT) && (cnt == 3'd1);
    assign gnt_ok  = !rst && ((state == IDLE) || rd_done);

`ifdef RV_MEM_ARB_RR_EN
    logic rr_last_d;  // 1: the data port was granted most recently

    // Remember which port won the last grant so the other one goes first next time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last_d <= 1'b0;
        end else if (if_gnt || d_gnt) begin
            rr_last_d <= d_gnt;
        end
    end

    assign pick_d = !rr_last_d;
`else
    // The data port carries the older instruction, so it wins a tie.
    assign pick_d = 1'b1;
`endif

    assign d_gnt  = gnt_ok && d_req_i && (!if_req_i || pick_d);
    assign if_gnt = gnt_ok && if_req_i && (!d_req_i || !pick_d);
    assign rd_gnt = if_gnt || (d_gnt && !d_we_i);

    // Steer the winner onto the memory port; everything is idle-zero otherwise.
    always_comb begin
        mem_addr_o  = 64'd0;
        mem_wdata_o = 64'd0;
        if (d_gnt) begin
            mem_addr_o  = d_addr_i;
            mem_wdata_o = d_wdata_i;
        end else if (if_gnt) begin
            mem_addr_o  = {if_addr_i[63:3], 3'b000};
        end
    end

    assign if_gnt_o = if_gnt;
    assign d_gnt_o  = d_gnt;
    assign mem_en_o = if_gnt || d_gnt;
    assign mem_we_o = d_gnt && d_we_i;
    assign busy_o   = (state == WAIT) && !rd_done;

    assign if_rvalid_o = rd_done && !owner_d;
    assign d_rvalid_o  = rd_done && owner_d;
    assign if_rdata_o  = if_rvalid_o ? (lane ? mem_rdata_i[63:32] : mem_rdata_i[31:0]) : 32'd0;
    assign d_rdata_o   = d_rvalid_o ? mem_rdata_i : 64'd0;

    // Track the outstanding read: owner, fetch lane and remaining latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            owner_d <= 1'b0;
            lane    <= 1'b0;
        end else if (rd_gnt) begin
            state   <= WAIT;
            cnt     <= 3'(MEM_LAT);
            owner_d <= d_gnt;
            if (if_gnt) begin
                lane <= if_addr_i[2];
            end
        end else if (state == WAIT) begin
            cnt <= cnt - 3'd1;
            if (rd_done) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_rv_mem_arb.sv
module tb_rv_mem_arb;

    localparam int NI = 3;  // instance k runs with MEM_LAT = k+1

    logic clk = 1'b0;
    logic rst;

    logic        if_req [NI];
    logic [63:0] if_addr [NI];
    logic        d_req [NI];
    logic        d_we [NI];
    logic [63:0] d_addr [NI];
    logic [63:0] d_wdata [NI];
    logic [63:0] mem_rdata [NI];

    logic        if_gnt [NI];
    logic        if_rvalid [NI];
    logic [31:0] if_rdata [NI];
    logic        d_gnt [NI];
    logic        d_rvalid [NI];
    logic [63:0] d_rdata [NI];
    logic        mem_en [NI];
    logic        mem_we [NI];
    logic [63:0] mem_addr [NI];
    logic [63:0] mem_wdata [NI];
    logic        busy [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        rv_mem_arb #(.MEM_LAT(g + 1)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .if_req_i    (if_req[g]),
            .if_addr_i   (if_addr[g]),
            .if_gnt_o    (if_gnt[g]),
            .if_rvalid_o (if_rvalid[g]),
            .if_rdata_o  (if_rdata[g]),
            .d_req_i     (d_req[g]),
            .d_we_i      (d_we[g]),
            .d_addr_i    (d_addr[g]),
            .d_wdata_i   (d_wdata[g]),
            .d_gnt_o     (d_gnt[g]),
            .d_rvalid_o  (d_rvalid[g]),
            .d_rdata_o   (d_rdata[g]),
            .mem_en_o    (mem_en[g]),
            .mem_we_o    (mem_we[g]),
            .mem_addr_o  (mem_addr[g]),
            .mem_wdata_o (mem_wdata[g]),
            .mem_rdata_i (mem_rdata[g]),
            .busy_o      (busy[g])
        );
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: one pending read with an absolute return cycle.
    bit mpend [NI];
    int mret [NI];
    bit mown_d [NI];
    bit mlane [NI];
    bit mlast_d [NI];
    int cyc;

    // Expected outputs for the current cycle.
    bit          e_if_gnt [NI];
    bit          e_d_gnt [NI];
    bit          e_if_rv [NI];
    bit          e_d_rv [NI];
    bit          e_busy [NI];
    logic [63:0] e_addr [NI];
    logic [63:0] e_wdata [NI];
    logic [31:0] e_if_rd [NI];
    logic [63:0] e_d_rd [NI];

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic clear_model();
        for (int k = 0; k < NI; k++) begin
            mpend[k] = 0; mret[k] = 0; mown_d[k] = 0; mlane[k] = 0; mlast_d[k] = 0;
        end
    endtask

    task automatic compute_expected();
        for (int k = 0; k < NI; k++) begin
            bit done, free, want_d;
            done = mpend[k] && (mret[k] == cyc);
            free = (!mpend[k] || done) && !rst;
`ifdef RV_MEM_ARB_RR_EN
            want_d = !mlast_d[k];
`else
            want_d = 1;
`endif
            e_d_gnt[k]  = free && d_req[k] && (!if_req[k] || want_d);
            e_if_gnt[k] = free && if_req[k] && (!d_req[k] || !want_d);
            e_busy[k]   = mpend[k] && !done;
            e_if_rv[k]  = done && !mown_d[k];
            e_d_rv[k]   = done && mown_d[k];
            e_if_rd[k]  = !e_if_rv[k] ? 32'd0 : (mlane[k] ? mem_rdata[k][63:32] : mem_rdata[k][31:0]);
            e_d_rd[k]   = e_d_rv[k] ? mem_rdata[k] : 64'd0;
            e_addr[k]   = e_d_gnt[k] ? d_addr[k] :
                          e_if_gnt[k] ? {if_addr[k][63:3], 3'b000} : 64'd0;
            e_wdata[k]  = e_d_gnt[k] ? d_wdata[k] : 64'd0;
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < NI; k++) begin
            string p;
            p = $sformatf("lat%0d_c%0d_", k + 1, cyc);
            check({p, "if_gnt"},    64'(if_gnt[k]),    64'(e_if_gnt[k]));
            check({p, "d_gnt"},     64'(d_gnt[k]),     64'(e_d_gnt[k]));
            check({p, "mem_en"},    64'(mem_en[k]),    64'(e_if_gnt[k] || e_d_gnt[k]));
            check({p, "mem_we"},    64'(mem_we[k]),    64'(e_d_gnt[k] && d_we[k]));
            check({p, "mem_addr"},  mem_addr[k],       e_addr[k]);
            check({p, "mem_wdata"}, mem_wdata[k],      e_wdata[k]);
            check({p, "busy"},      64'(busy[k]),      64'(e_busy[k]));
            check({p, "if_rvalid"}, 64'(if_rvalid[k]), 64'(e_if_rv[k]));
            check({p, "if_rdata"},  64'(if_rdata[k]),  64'(e_if_rd[k]));
            check({p, "d_rvalid"},  64'(d_rvalid[k]),  64'(e_d_rv[k]));
            check({p, "d_rdata"},   d_rdata[k],        e_d_rd[k]);
        end
    endtask

    // Advance the model across the clock edge just taken.
    task automatic update_model();
        for (int k = 0; k < NI; k++) begin
            if (mpend[k] && mret[k] == cyc) mpend[k] = 0;
            if (e_if_gnt[k] || (e_d_gnt[k] && !d_we[k])) begin
                mpend[k]  = 1;
                mret[k]   = cyc + k + 1;
                mown_d[k] = e_d_gnt[k];
                if (e_if_gnt[k]) mlane[k] = if_addr[k][2];
            end
            if (e_if_gnt[k] || e_d_gnt[k]) mlast_d[k] = e_d_gnt[k];
            if (e_if_gnt[k]) if_req[k] = 0;
            if (e_d_gnt[k])  d_req[k]  = 0;
        end
    endtask

    // Requesters raise a new request at random and hold it until granted.
    task automatic drive_stimulus();
        rst = ($urandom_range(0, 79) == 0);
        for (int k = 0; k < NI; k++) begin
            mem_rdata[k] = rnd64();
            if (!if_req[k] && $urandom_range(0, 1) == 1) begin
                if_req[k]  = 1;
                if_addr[k] = {rnd64() >> 3, $urandom_range(0, 1) == 1, 2'b00};
            end
            if (!d_req[k] && $urandom_range(0, 1) == 1) begin
                d_req[k]   = 1;
                d_we[k]    = ($urandom_range(0, 2) == 0);
                d_addr[k]  = {rnd64() >> 3, 3'b000};
                d_wdata[k] = rnd64();
            end
        end
        if (rst) clear_model();
    endtask

    initial begin
        rst = 1;
        cyc = 0;
        for (int k = 0; k < NI; k++) begin
            if_req[k] = 0; if_addr[k] = 0; d_req[k] = 0; d_we[k] = 0;
            d_addr[k] = 0; d_wdata[k] = 0; mem_rdata[k] = 64'hAAAA_BBBB_CCCC_DDDD;
        end
        clear_model();
        compute_expected();
        @(negedge clk);
        check_all();
        @(posedge clk);
        #1;
        for (int n = 0; n < 4000; n++) begin
            drive_stimulus();
            compute_expected();
            @(negedge clk);
            check_all();
            @(posedge clk);
            #1;
            if (!rst) update_model();
            cyc++;
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
